// File: rtl/round_constant_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | round_constant_sequencer_pkg                                               |
// | Shared constants, FSM/direction encodings and last-index helper.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package round_constant_sequencer_pkg;

  localparam int ROUNDS = 14;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 128;
  localparam int ROW_W  = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic {
    DIR_ENC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // Encryption ends on the top index, decryption on index 1.
  function automatic logic is_final(input logic [CNT_W-1:0] idx,
                                    input dir_e             dir,
                                    input logic [CNT_W-1:0] top);
    return (dir == DIR_DEC) ? (idx == CNT_W'(1)) : (idx == top);
  endfunction

endpackage
`default_nettype wire

// File: rtl/Round_Constants.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Round_Constants                                                            |
// | Combinational Anubis round-constant lookup: row 0 = S[4(r-1)..4r-1].       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module Round_Constants
  import round_constant_sequencer_pkg::*;
(
  input  logic [CNT_W-1:0]  round_counter,
  output logic [DATA_W-1:0] data_out
);

  logic [ROW_W-1:0] w_row;

  // Only the first matrix row is non-zero; indices outside 1..14 give zero.
  always_comb begin
    w_row = '0;
    case (round_counter)
      4'd1:    w_row = 32'hba542f74;
      4'd2:    w_row = 32'h53d3d24d;
      4'd3:    w_row = 32'h50ac8dbf;
      4'd4:    w_row = 32'h70529a4c;
      4'd5:    w_row = 32'head597d1;
      4'd6:    w_row = 32'h33515ba6;
      4'd7:    w_row = 32'hde48a899;
      4'd8:    w_row = 32'hdb32b7fc;
      4'd9:    w_row = 32'he39e919b;
      4'd10:   w_row = 32'he2bb416e;
      4'd11:   w_row = 32'ha5cb6b95;
      4'd12:   w_row = 32'ha1f3b102;
      4'd13:   w_row = 32'hccc41d14;
      4'd14:   w_row = 32'hc363da5d;
      default: w_row = '0;
    endcase
  end

  assign data_out = {w_row, {(DATA_W-ROW_W){1'b0}}};

endmodule
`default_nettype wire

// File: rtl/round_constant_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | round_constant_sequencer                                                   |
// | Streams ROUNDS key-schedule constants, forward or reverse, over valid/ready|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module round_constant_sequencer
  import round_constant_sequencer_pkg::*;
#(
  parameter int ROUNDS = round_constant_sequencer_pkg::ROUNDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic              abort,
  input  logic              rc_ready,
  output logic              rc_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  round_counter,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] C_FIRST_IDX = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST_IDX  = CNT_W'(ROUNDS);

  logic [1:0]        r_state;
  dir_e              r_dir;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  dir_e              w_next_dir;
  logic [CNT_W-1:0]  w_next_idx;
  logic              w_next_last;
  logic [DATA_W-1:0] w_rc;
  logic              w_xfer;

  assign w_xfer = r_valid & rc_ready;

  // In IDLE the mux offers the start index; otherwise the +/-1 step.
  // The step result is only consumed on a non-final transfer, so it never wraps.
  always_comb begin
    w_next_dir = r_dir;
    w_next_idx = (r_dir == DIR_DEC) ? (r_idx - CNT_W'(1)) : (r_idx + CNT_W'(1));
    if (r_state == ST_IDLE) begin
      w_next_dir = dir_e'(decrypt);
      w_next_idx = decrypt ? C_LAST_IDX : C_FIRST_IDX;
    end
  end

  assign w_next_last = is_final(w_next_idx, w_next_dir, C_LAST_IDX);

  Round_Constants u_round_constants (
    .round_counter (w_next_idx),
    .data_out      (w_rc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_ENC;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ISSUE;
            r_dir   <= w_next_dir;
            r_idx   <= w_next_idx;
            r_data  <= w_rc;
            r_valid <= 1'b1;
            r_last  <= w_next_last;
          end
        end
        ST_ISSUE: begin
          // Abort wins over a coincident transfer: that constant is consumed,
          // but the run ends without a done pulse.
          if (abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_xfer) begin
            if (r_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_rc;
              r_last <= w_next_last;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rc_valid      = r_valid;
  assign data_out      = r_data;
  assign round_counter = r_idx;
  assign last          = r_last;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_round_constant_sequencer.sv
`default_nettype none
// Scoreboard bench: main thread drives runs and queues expected constants,
// a negedge monitor pops and compares every accepted transfer.
module tb_round_constant_sequencer;

  logic         clk = 1'b0;
  logic         rst, start, decrypt, abort, rc_ready;
  logic         rc_valid, last, busy, done;
  logic [127:0] data_out;
  logic [3:0]   round_counter;

  logic         start1, decrypt1, abort1, ready1;
  logic         rc_valid1, last1, busy1, done1;
  logic [127:0] data_out1;
  logic [3:0]   round_counter1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         lst;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  round_constant_sequencer #(.ROUNDS(14)) u_dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .abort(abort),
    .rc_ready(rc_ready), .rc_valid(rc_valid), .data_out(data_out),
    .round_counter(round_counter), .last(last), .busy(busy), .done(done)
  );

  round_constant_sequencer #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .decrypt(decrypt1), .abort(abort1),
    .rc_ready(ready1), .rc_valid(rc_valid1), .data_out(data_out1),
    .round_counter(round_counter1), .last(last1), .busy(busy1), .done(done1)
  );

  // Hand-entered Anubis constants: row 0 holds S-box bytes 4(r-1)..4r-1.
  function automatic logic [127:0] exp_rc(input int r);
    logic [31:0] row;
    case (r)
      1: row = 32'hba542f74;   2: row = 32'h53d3d24d;   3: row = 32'h50ac8dbf;
      4: row = 32'h70529a4c;   5: row = 32'head597d1;   6: row = 32'h33515ba6;
      7: row = 32'hde48a899;   8: row = 32'hdb32b7fc;   9: row = 32'he39e919b;
      10: row = 32'he2bb416e; 11: row = 32'ha5cb6b95; 12: row = 32'ha1f3b102;
      13: row = 32'hccc41d14; 14: row = 32'hc363da5d;
      default: row = 32'h0;
    endcase
    return {row, 96'h0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue expected transfers from index a to b (inclusive) in either direction.
  task automatic push_run(input int a, input int b, input int fin);
    exp_t e;
    int step = (b >= a) ? 1 : -1;
    for (int r = a; r != b + step; r += step) begin
      e.idx  = 4'(r);
      e.data = exp_rc(r);
      e.lst  = (r == fin);
      sbq.push_back(e);
    end
  endtask

  // Monitor: compare each accepted constant and check holds across stalls.
  logic         prev_stall = 1'b0;
  logic [3:0]   prev_idx;
  logic [127:0] prev_data;
  logic         prev_last;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rc_valid) begin
        if (prev_stall) begin
          chk("stall_hold_idx", round_counter, prev_idx);
          chk("stall_hold_data", data_out, prev_data);
          chk("stall_hold_last", last, prev_last);
        end
        if (rc_ready) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got idx %0d expected no transfer", round_counter);
          end else begin
            e = sbq.pop_front();
            chk("sb_idx", round_counter, e.idx);
            chk("sb_data", data_out, e.data);
            chk("sb_last", last, e.lst);
          end
        end
      end
      prev_stall = rc_valid && !rc_ready;
      prev_idx   = round_counter;
      prev_data  = data_out;
      prev_last  = last;
    end
  end

  task automatic start_run(input logic dec);
    @(posedge clk); #1 start = 1'b1; decrypt = dec;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("latency_valid", rc_valid, 1'b1);
    chk("start_idx", round_counter, dec ? 4'd14 : 4'd1);
    chk("busy_run", busy, 1'b1);
  endtask

  task automatic run_to_done(input logic bp);
    logic [3:0] pat = 4'b1001;
    bit hit = 0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(posedge clk); #1;
      if (bp) rc_ready = pat[cyc % 4];
      @(negedge clk);
      if (done) hit = 1;
    end
    chk("done_pulse", hit, 1'b1);
    @(posedge clk); #1 rc_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", rc_valid, 1'b0);
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic wait_idx(input logic [3:0] v);
    bit hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (rc_valid && round_counter == v) hit = 1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL wait_idx: got timeout expected index %0d", v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, rc_valid, 1'b0);
    chk({tag, "_last"}, last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_data"}, data_out, 128'h0);
    chk({tag, "_cnt"}, round_counter, 4'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; rc_ready = 1'b0;
    start1 = 1'b0; decrypt1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    chk("reset1_valid", rc_valid1, 1'b0);
    chk("reset1_busy", busy1, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Encrypt at full rate.
    rc_ready = 1'b1;
    push_run(1, 14, 14);
    start_run(1'b0);
    run_to_done(1'b0);

    // Decrypt with back-pressure 1,0,0,1.
    push_run(14, 1, 1);
    start_run(1'b1);
    run_to_done(1'b1);

    // Start with flipped decrypt while busy is ignored.
    push_run(1, 14, 14);
    start_run(1'b0);
    wait_idx(4'd5);
    start = 1'b1; decrypt = 1'b1;
    @(posedge clk); #1 start = 1'b0; decrypt = 1'b0;
    run_to_done(1'b0);

    // Abort together with the transfer of index 3.
    push_run(1, 3, 14);
    start_run(1'b0);
    wait_idx(4'd3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", rc_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    chk("abort_sb_drained", sbq.size(), 0);
    push_run(1, 14, 14);
    start_run(1'b0);
    run_to_done(1'b0);

    // Reset in the middle of a decrypt run.
    push_run(14, 9, 1);
    start_run(1'b1);
    wait_idx(4'd9);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    chk("midrst_sb_drained", sbq.size(), 0);

    // Single-round build, encrypt then decrypt.
    for (int d = 0; d < 2; d++) begin
      ready1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b1; decrypt1 = d[0];
      @(posedge clk); #1 start1 = 1'b0;
      @(negedge clk);
      chk("r1_valid", rc_valid1, 1'b1);
      chk("r1_idx", round_counter1, 4'd1);
      chk("r1_last", last1, 1'b1);
      chk("r1_data", data_out1, exp_rc(1));
      @(negedge clk);
      chk("r1_valid_drop", rc_valid1, 1'b0);
      chk("r1_done", done1, 1'b1);
      @(negedge clk);
      chk("r1_done_end", done1, 1'b0);
      chk("r1_busy_end", busy1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
